// File: rtl/shift_sequencer.sv
// Multi-cycle register-specified barrel shift (LSL/LSR/ASR/ROR) with ARM carry-out, STEP bits per cycle.
// Latency ceil(eff/STEP)+1 cycles from accepted start to done; stall holds the pipeline until done.
module shift_sequencer #(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  shift_type,
    input  logic [31:0] val_rm,
    input  logic [7:0]  shift_amt,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] result,
    output logic        carry_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;

    localparam logic [5:0] STEP_W = 6'(STEP);

    logic [1:0]  state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [5:0]  rem_q, rem_d;
    logic [31:0] work_q, work_d;
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;

    logic        start_acc;
    logic [5:0]  eff;
    logic [5:0]  k;
    logic        fill;
    logic [32:0] lsl_s;
    logic [32:0] rsh_s;
    logic [31:0] rot_s;
    logic [31:0] step_val;
    logic        step_c;

    always_comb begin
        start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);

        // Clamp so that a multi-step shift reproduces the >=32 corner cases naturally.
        case (shift_type)
            SH_LSL, SH_LSR: eff = (shift_amt > 8'd33) ? 6'd33 : shift_amt[5:0];
            SH_ASR:         eff = (shift_amt > 8'd32) ? 6'd32 : shift_amt[5:0];
            default: begin
                if (shift_amt == 8'd0)
                    eff = 6'd0;
                else if (shift_amt[4:0] == 5'd0)
                    eff = 6'd32;
                else
                    eff = {1'b0, shift_amt[4:0]};
            end
        endcase

        k    = (rem_q < STEP_W) ? rem_q : STEP_W;
        fill = (type_q == SH_ASR) && work_q[31];

        // Extra low/high bit in each vector captures the last bit shifted out.
        lsl_s = {1'b0, work_q} << k;
        rsh_s = 33'($signed({fill, work_q, 1'b0}) >>> k);
        rot_s = 32'({work_q, work_q} >> k);

        case (type_q)
            SH_LSL: begin
                step_val = lsl_s[31:0];
                step_c   = lsl_s[32];
            end
            SH_LSR, SH_ASR: begin
                step_val = rsh_s[32:1];
                step_c   = rsh_s[0];
            end
            default: begin
                step_val = rot_s;
                step_c   = rot_s[31];
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        rem_d    = rem_q;
        work_d   = work_q;
        result_d = result_q;
        carry_d  = carry_q;

        case (state_q)
            ST_SHIFT: begin
                work_d = step_val;
                rem_d  = rem_q - k;
                if (rem_q == k) begin
                    result_d = step_val;
                    carry_d  = step_c;
                    state_d  = ST_DONE;
                end
            end
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_acc) begin
                    type_d = shift_type;
                    work_d = val_rm;
                    rem_d  = eff;
                    if (eff == 6'd0) begin
                        result_d = val_rm;
                        carry_d  = carry_in;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            type_q   <= 2'd0;
            rem_q    <= 6'd0;
            work_q   <= 32'h0;
            result_q <= 32'h0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            rem_q    <= rem_d;
            work_q   <= work_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign stall     = start_acc || busy;
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle sequencer for register-specified shifts (`Rm <shift> Rs`) in the execute stage. The single-cycle Value2 path covers only immediate-specified shifts. This block covers the register form instead. It takes the shift amount from `Rs[7:0]`, applies full ARM semantics including shifter carry-out, and processes at most STEP bit positions per cycle. It stalls the pipeline through `stall` until the result is ready.

## Interface
- STEP, 8, maximum bit positions shifted per cycle; legal range 1..32.

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a shift; sampled in IDLE and DONE only
- shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- val_rm  input  32  operand to shift
- shift_amt  input  8  Rs[7:0]
- carry_in  input  1  current CPSR C flag
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when result/carry_out become valid
- stall  output  1  combinational; start_accepted OR busy; freezes IF/ID/EXE
- result  output  32  shifted value; held until next accepted start
- carry_out  output  1  shifter carry-out; held with result

## Operation
- States: IDLE, SHIFT, DONE.
- An accepted start means start=1 while in IDLE or DONE. It latches val_rm, shift_type and carry_in, and computes eff. Start during SHIFT is ignored.
- Effective amount eff (6 bits):
  - LSL/LSR: min(shift_amt, 33).
  - ASR: min(shift_amt, 32).
  - ROR: 0 if shift_amt==0; 32 if shift_amt[4:0]==0; otherwise shift_amt[4:0].
- eff==0 on any type: result=val_rm, carry_out=carry_in. Next state is DONE directly.
- eff>0: next state is SHIFT, with remaining=eff and the working register loaded with val_rm.
- Each SHIFT cycle applies k=min(remaining, STEP) positions and decrements remaining by k.
  - LSL and LSR zero-fill. ASR sign-fills. ROR rotates.
  - Working carry = the last bit shifted or rotated out this cycle. For LSL that is bit (32-k) of the pre-step value, or 0 if that index is below 0. For LSR/ASR/ROR it is bit (k-1), or the fill bit if the index is at or above 32.
  - When remaining reaches 0: result and carry_out load from the working values, and the next state is DONE.
- The clamping yields the architectural corner cases:
  - LSL 32 → 0, C=Rm[0]. LSL >32 → 0, C=0.
  - LSR 32 → 0, C=Rm[31]. LSR >32 → 0, C=0.
  - ASR ≥32 → all Rm[31], C=Rm[31].
  - ROR by a multiple of 32 → Rm, C=Rm[31].
- DONE: done=1 for exactly this cycle. Without an accepted start, the next state is IDLE.
- Reset (rst_n=0 at an edge), including mid-SHIFT: state=IDLE. busy, done, result and carry_out become 0 and any in-flight operation is discarded.

## Timing
- Accepted start at cycle T, with N = ceil(eff/STEP) (N=0 when eff=0). done is high in cycle T+1+N and result is valid from that cycle.
- stall is high from T through T+N. It is low in the done cycle, so EXE consumes the result there.
- busy is high in T+1 .. T+N.
- Back-to-back: a start in the DONE cycle is accepted. stall is high again in that same cycle.
- Reset values: busy=0, done=0, stall=start_accepted (0 unless start=1 in IDLE), result=32'h0, carry_out=0.

## Test plan
- STEP=8, LSL, val_rm=0x8000_0001, amt=1, cin=0, start at T: stall=1 at T and T+1, busy=1 at T+1; done at T+2 with result=0x0000_0002, C=1.
- ROR, amt=0, val_rm=0x1234_5678, cin=1: done at T+1, result=0x1234_5678, C=1, busy never asserted.
- LSR, val_rm=0x8000_0000, amt=32: done at T+5, result=0, C=1. Repeat with amt=40: done at T+6, result=0, C=0.
- ASR, val_rm=0x8000_0000, amt=200: done at T+5, result=0xFFFF_FFFF, C=1. ROR, val_rm=0x0000_000F, amt=4: result=0xF000_0000, C=1. ROR, val_rm=0x8000_0001, amt=32: result=0x8000_0001, C=1.
- Repeat LSL amt=33 with STEP=1 (done at T+34, result=0, C=0) and STEP=32 (done at T+3).
- LSL amt=33 started at T. A second start at T+2 is ignored. rst_n=0 at the T+3 edge gives busy=0, done=0, result=0, C=0 at T+4. Then a start at T+5 with amt=0 gives done at T+6.
